// File: rtl/cpu_pkg.sv
// Shared definitions for the RAM image loader: state encoding, error codes,
// default RAM geometry and small state-classification helpers.
package cpu_pkg;

    localparam int RAM_WIDTH_DEFAULT     = 16;
    localparam int RAM_ADDR_BITS_DEFAULT = 12;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LEN_HI = 4'd1;
    localparam logic [3:0] ST_LEN_LO = 4'd2;
    localparam logic [3:0] ST_DAT_HI = 4'd3;
    localparam logic [3:0] ST_DAT_LO = 4'd4;
    localparam logic [3:0] ST_SUM_HI = 4'd5;
    localparam logic [3:0] ST_SUM_LO = 4'd6;
    localparam logic [3:0] ST_VERIFY = 4'd7;
    localparam logic [3:0] ST_DRAIN  = 4'd8;
    localparam logic [3:0] ST_CHECK  = 4'd9;
    localparam logic [3:0] ST_DONE   = 4'd10;
    localparam logic [3:0] ST_ERR    = 4'd11;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_SUM  = 2'd2;

    // States in which the loader takes bytes from the receiver.
    function automatic logic is_byte_state(input logic [3:0] st);
        return st inside {ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO, ST_SUM_HI, ST_SUM_LO};
    endfunction

    // Resting states: the only ones where a start pulse is honoured.
    function automatic logic is_rest_state(input logic [3:0] st);
        return st inside {ST_IDLE, ST_DONE, ST_ERR};
    endfunction

endpackage

// File: rtl/ram_loader_verify_accum.sv
// Read-back checksum: delays the read-issue flag to line up with RAM data,
// accumulates a wrapping sum and compares it with the frame trailer.
module verify_accum
    import cpu_pkg::*;
#(
    parameter int WIDTH = RAM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             rd_issue,
    input  logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] expected,
    output logic             match
);

    logic             rd_valid_reg;
    logic [WIDTH-1:0] acc_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_valid_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            // RAM data for a read issued in cycle t is present in cycle t+1.
            rd_valid_reg <= rd_issue;
            if (rd_valid_reg) begin
                acc_reg <= acc_reg + rd_data;
            end
        end
    end

    assign match = (acc_reg == expected);

endmodule

// File: rtl/ram_loader.sv
// Loads a length/data/checksum framed byte stream into block RAM from address 0,
// then reads the image back and verifies its sum against the trailer.
module ram_loader
    import cpu_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEFAULT,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     ram_en,
    output logic                     ram_wr_en,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_data_in,
    input  logic [RAM_WIDTH-1:0]     ram_data_out,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err_code
);

    // Word counts need one extra bit so a full 2**RAM_ADDR_BITS image is representable.
    localparam int CNT_W = RAM_ADDR_BITS + 1;

    logic [3:0]               state_reg, state_next;
    logic                     byte_ready_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic [1:0]               err_code_reg;
    logic                     ram_en_reg;
    logic                     ram_wr_en_reg;
    logic [RAM_ADDR_BITS-1:0] ram_addr_reg;
    logic [RAM_WIDTH-1:0]     ram_data_in_reg;

    logic [7:0]               len_hi_reg;
    logic [7:0]               dat_hi_reg;
    logic [7:0]               sum_hi_reg;
    logic [CNT_W-1:0]         len_reg;
    logic [RAM_WIDTH-1:0]     sum_reg;
    logic [RAM_ADDR_BITS-1:0] wptr_reg;
    logic [CNT_W-1:0]         rptr_reg;

    logic        accept;
    logic        start_ok;
    logic [15:0] len_word;
    logic        len_over;
    logic        len_zero;
    logic        last_word;
    logic        sum_match;

    assign accept    = byte_valid && byte_ready_reg;
    assign start_ok  = start && is_rest_state(state_reg);
    assign len_word  = {len_hi_reg, byte_data};
    assign len_over  = {16'd0, len_word} > (32'd1 << RAM_ADDR_BITS);
    assign len_zero  = (len_word == 16'd0);
    assign last_word = ({1'b0, wptr_reg} + CNT_W'(1)) == len_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: if (accept) state_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_over)      state_next = ST_ERR;
                    else if (len_zero) state_next = ST_SUM_HI;
                    else               state_next = ST_DAT_HI;
                end
            end
            ST_DAT_HI: if (accept) state_next = ST_DAT_LO;
            ST_DAT_LO: if (accept) state_next = last_word ? ST_SUM_HI : ST_DAT_HI;
            ST_SUM_HI: if (accept) state_next = ST_SUM_LO;
            // An empty image skips straight to DRAIN so the verdict still lands two edges later.
            ST_SUM_LO: if (accept) state_next = (len_reg == '0) ? ST_DRAIN : ST_VERIFY;
            ST_VERIFY: if (rptr_reg == len_reg) state_next = ST_DRAIN;
            ST_DRAIN:  state_next = ST_CHECK;
            ST_CHECK:  state_next = sum_match ? ST_DONE : ST_ERR;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            byte_ready_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_code_reg    <= ERR_NONE;
            ram_en_reg      <= 1'b0;
            ram_wr_en_reg   <= 1'b0;
            ram_addr_reg    <= '0;
            ram_data_in_reg <= '0;
            len_hi_reg      <= '0;
            dat_hi_reg      <= '0;
            sum_hi_reg      <= '0;
            len_reg         <= '0;
            sum_reg         <= '0;
            wptr_reg        <= '0;
            rptr_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            byte_ready_reg <= is_byte_state(state_next);
            busy_reg       <= !is_rest_state(state_next);
            // RAM strobes are single-cycle unless re-armed below.
            ram_en_reg     <= 1'b0;
            ram_wr_en_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_ok) begin
                        done_reg     <= 1'b0;
                        err_code_reg <= ERR_NONE;
                        wptr_reg     <= '0;
                        rptr_reg     <= '0;
                    end
                end
                ST_LEN_HI: if (accept) len_hi_reg <= byte_data;
                ST_LEN_LO: begin
                    if (accept) begin
                        len_reg <= CNT_W'(len_word);
                        if (len_over) err_code_reg <= ERR_LEN;
                    end
                end
                ST_DAT_HI: if (accept) dat_hi_reg <= byte_data;
                ST_DAT_LO: begin
                    if (accept) begin
                        ram_en_reg      <= 1'b1;
                        ram_wr_en_reg   <= 1'b1;
                        ram_addr_reg    <= wptr_reg;
                        ram_data_in_reg <= RAM_WIDTH'({dat_hi_reg, byte_data});
                        wptr_reg        <= wptr_reg + 1'b1;
                    end
                end
                ST_SUM_HI: if (accept) sum_hi_reg <= byte_data;
                ST_SUM_LO: begin
                    if (accept) begin
                        sum_reg <= RAM_WIDTH'({sum_hi_reg, byte_data});
                        if (len_reg != '0) begin
                            ram_en_reg   <= 1'b1;
                            ram_addr_reg <= '0;
                            rptr_reg     <= CNT_W'(1);
                        end
                    end
                end
                ST_VERIFY: begin
                    if (rptr_reg != len_reg) begin
                        ram_en_reg   <= 1'b1;
                        ram_addr_reg <= rptr_reg[RAM_ADDR_BITS-1:0];
                        rptr_reg     <= rptr_reg + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (sum_match) done_reg     <= 1'b1;
                    else           err_code_reg <= ERR_SUM;
                end
                default: ;
            endcase
        end
    end

    verify_accum #(
        .WIDTH (RAM_WIDTH)
    ) u_verify_accum (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .rd_issue (ram_en_reg && !ram_wr_en_reg),
        .rd_data  (ram_data_out),
        .expected (sum_reg),
        .match    (sum_match)
    );

    assign byte_ready  = byte_ready_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err_code    = err_code_reg;
    assign ram_en      = ram_en_reg;
    assign ram_wr_en   = ram_wr_en_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_data_in = ram_data_in_reg;

endmodule

// File: tb/tb_ram_loader.sv
// Randomised frame bench for ram_loader with a behavioural RAM and a
// frame-level reference model (expected writes, reads, verdict and latency).
module tb_ram_loader;

    localparam int AW    = 12;
    localparam int W     = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          ram_en;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_data_in;
    logic [W-1:0]  ram_data_out;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;

    ram_loader #(
        .RAM_WIDTH     (W),
        .RAM_ADDR_BITS (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .ram_en       (ram_en),
        .ram_wr_en    (ram_wr_en),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .busy         (busy),
        .done         (done),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM with registered read.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) mem[ram_addr] <= ram_data_in;
            else           ram_data_out  <= mem[ram_addr];
        end
    end

    // Bus monitor: running totals, sampled mid-cycle.
    int          en_tot = 0;
    int          rd_tot = 0;
    int          wr_tot = 0;
    logic [31:0] wr_log [65536];
    always @(negedge clk) begin
        if (ram_en) begin
            en_tot <= en_tot + 1;
            if (ram_wr_en) begin
                wr_log[wr_tot] <= {4'd0, ram_addr, ram_data_in};
                wr_tot <= wr_tot + 1;
            end else begin
                rd_tot <= rd_tot + 1;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] ref_w [DEPTH];
    logic [7:0]  frame_q [$];

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns the edge number of the last accepted byte.
    task automatic send_frame(input bit gap, output int unsigned acc_cyc, output int drops);
        drops   = 0;
        acc_cyc = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            int waited = 0;
            byte_valid = 1'b1;
            byte_data  = frame_q[i];
            while (byte_ready !== 1'b1) begin
                @(negedge clk);
                waited++;
                if (waited > 50) begin
                    chk("ready_timeout", 32'd0, 32'd1);
                    byte_valid = 1'b0;
                    return;
                end
            end
            @(negedge clk);
            acc_cyc    = cyc;
            byte_valid = 1'b0;
            if (gap && i < frame_q.size() - 1) begin
                if (byte_ready !== 1'b1) drops++;
                @(negedge clk);
                if (byte_ready !== 1'b1) drops++;
            end
        end
    endtask

    task automatic wait_outcome(output int unsigned oc_cyc);
        oc_cyc = 0;
        for (int k = 0; k < 20000; k++) begin
            if (done === 1'b1 || (err_code !== 2'd0)) begin
                oc_cyc = cyc;
                return;
            end
            @(negedge clk);
        end
        chk("outcome_timeout", 32'd0, 32'd1);
    endtask

    // Frame of n words from ref_w with the given trailer; overflow frames send LEN only.
    task automatic run_frame(input string tag, input int n, input logic [15:0] trailer, input bit gap);
        int unsigned acc_cyc, oc_cyc;
        int          drops, en0, rd0, wr0;
        int unsigned sum;
        bit          over;
        logic [15:0] nw;
        logic [AW-1:0] a;
        over = (n > DEPTH);
        nw   = 16'(n);
        frame_q.delete();
        frame_q.push_back(nw[15:8]);
        frame_q.push_back(nw[7:0]);
        sum = 0;
        if (!over) begin
            for (int i = 0; i < n; i++) begin
                frame_q.push_back(ref_w[i][15:8]);
                frame_q.push_back(ref_w[i][7:0]);
                sum = (sum + ref_w[i]) % 65536;
            end
            frame_q.push_back(trailer[15:8]);
            frame_q.push_back(trailer[7:0]);
        end
        en0 = en_tot; rd0 = rd_tot; wr0 = wr_tot;
        pulse_start();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        send_frame(gap, acc_cyc, drops);
        wait_outcome(oc_cyc);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        if (over) begin
            chk({tag, "_err"}, 32'(err_code), 32'd1);
            chk({tag, "_done"}, 32'(done), 32'd0);
            chk({tag, "_ram_en"}, 32'(en_tot - en0), 32'd0);
        end else begin
            chk({tag, "_done"}, 32'(done), (sum == trailer) ? 32'd1 : 32'd0);
            chk({tag, "_err"}, 32'(err_code), (sum == trailer) ? 32'd0 : 32'd2);
            chk({tag, "_latency"}, 32'(oc_cyc - acc_cyc), 32'(n + 2));
            chk({tag, "_nwr"}, 32'(wr_tot - wr0), 32'(n));
            chk({tag, "_nrd"}, 32'(rd_tot - rd0), 32'(n));
            if (gap) chk({tag, "_ready_drops"}, 32'(drops), 32'd0);
            if (wr_tot - wr0 == n) begin
                for (int i = 0; i < n; i++) begin
                    a = AW'(i);
                    chk({tag, "_wr"}, wr_log[wr0 + i], {4'd0, a, ref_w[i]});
                end
            end
        end
        $display("frame %s n=%0d trailer=%04h done=%0b err=%0d latency=%0d",
                 tag, n, trailer, done, err_code, oc_cyc - acc_cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(ram_data_in), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ac;
        int          dr;
        int          n;
        logic [15:0] s;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        ref_w[0] = 16'h1234; ref_w[1] = 16'h0001; ref_w[2] = 16'hFFFF;
        run_frame("basic", 3, 16'h1234, 1'b0);
        run_frame("badsum", 3, 16'h1235, 1'b0);
        run_frame("overflow", 4097, 16'h0000, 1'b0);
        run_frame("empty", 0, 16'h0000, 1'b0);
        run_frame("gapped", 3, 16'h1234, 1'b1);

        // Reset after the second data word of a three-word frame.
        frame_q.delete();
        frame_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h00, 8'h01};
        pulse_start();
        send_frame(1'b0, ac, dr);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
        @(negedge clk);
        run_frame("after_reset", 3, 16'h1234, 1'b0);

        // Largest legal image.
        s = 16'd0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_w[i] = 16'($urandom);
            s = s + ref_w[i];
        end
        run_frame("full", DEPTH, s, 1'b0);

        for (int t = 0; t < 12; t++) begin
            n = int'($urandom_range(0, 24));
            s = 16'd0;
            for (int i = 0; i < n; i++) begin
                ref_w[i] = 16'($urandom);
                s = s + ref_w[i];
            end
            if ($urandom_range(0, 9) < 3) s = s ^ 16'(1 << $urandom_range(0, 15));
            run_frame($sformatf("rand%0d", t), n, s, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Write-side initiator for the 16-bit program/data block RAM: takes a byte stream from the UART receiver and writes a framed image into RAM from address 0.
- After the writes it reads the image back, sums it, and checks the sum against the frame trailer.
- Sits between the UART receiver and the RAM port, and holds the CPU off the RAM while busy.

Parameters:
- RAM_WIDTH, 16, RAM word width. Must be 16: the frame format is two bytes per word.
- RAM_ADDR_BITS, 12, RAM address width. Maximum image is 2**RAM_ADDR_BITS words.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load. Acted on only in IDLE, DONE or ERR.
- byte_valid  in  1  receiver byte available.
- byte_data  in  8  receiver byte.
- byte_ready  out  1  loader accepts a byte. Transfer occurs when byte_valid && byte_ready.
- ram_en  out  1  RAM enable.
- ram_wr_en  out  1  RAM write enable.
- ram_addr  out  RAM_ADDR_BITS  RAM address.
- ram_data_in  out  RAM_WIDTH  write data to RAM.
- ram_data_out  in  RAM_WIDTH  RAM read data; valid one cycle after a read is issued.
- busy  out  1  high in any state other than IDLE, DONE or ERR; CPU RAM access is gated off while high.
- done  out  1  load and verify passed. Held high until the next accepted start or reset.
- err_code  out  2  0 = none, 1 = length overflow, 2 = checksum mismatch. Held until the next accepted start or reset.

Behaviour:
- Frame format (all fields big-endian):
  - LEN: 16-bit word count N.
  - N data words.
  - SUM: 16-bit wrapping sum of the data words.
- Reset:
  - State goes to IDLE.
  - All outputs are 0: byte_ready, ram_en, ram_wr_en, ram_addr, ram_data_in, busy, done, err_code.
  - Reset asserted mid-load cancels any write pending that cycle; RAM contents written so far remain.
- States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO, VERIFY, DRAIN, CHECK, DONE, ERR.
- Start:
  - start in IDLE, DONE or ERR goes to LEN_HI.
  - It clears done and err_code, write pointer, read pointer and accumulator.
  - start in any other state is ignored.
- byte_ready:
  - Registered; high exactly in LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI and SUM_LO.
  - Each accepted byte advances the state by one step.
  - With byte_valid low, the state holds indefinitely (no timeout).
- Length handling (byte accepted in LEN_LO):
  - N > 2**RAM_ADDR_BITS: go to ERR with err_code = 1. No RAM access occurs.
  - N == 0: go to SUM_HI.
  - Otherwise: go to DAT_HI.
- Data words and writes:
  - DAT_HI latches the high byte.
  - Accepting the byte in DAT_LO registers a write: on the next cycle ram_en = 1, ram_wr_en = 1, ram_addr = wptr, ram_data_in = {hi, lo}. The write lasts exactly one cycle, then wptr increments.
  - byte_ready stays high, so back-to-back bytes are legal.
  - After word N goes to SUM_HI; otherwise returns to DAT_HI.
- Verify:
  - Accepting SUM_LO latches the expected sum and goes to VERIFY.
  - VERIFY issues reads at addr 0 to N-1, one per cycle, with ram_en = 1 and ram_wr_en = 0.
  - A one-cycle-delayed valid flag adds ram_data_out into a 16-bit wrapping accumulator.
  - DRAIN absorbs the final read's data. CHECK compares the accumulator to the expected sum.
- Verify timing:
  - ram_en is high for exactly N consecutive cycles, starting the cycle after SUM_LO acceptance.
  - done or err_code is updated at edge N+2 after that acceptance. For N = 0 this is edge 2.
- Outcome:
  - Match: go to DONE with done = 1.
  - Mismatch: go to ERR with err_code = 2.
- Boundaries:
  - N == 2**RAM_ADDR_BITS is legal. wptr wraps to 0 only after the final write and is not used again.
  - ram_en is 0 in every state except a write cycle or VERIFY.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding localparams.
  - ERR_NONE, ERR_LEN, ERR_SUM codes.
  - RAM_WIDTH and RAM_ADDR_BITS defaults.
- Sub-module: verify_accum, holding the delayed-valid flag, the accumulator and the compare.
- The FSM and byte assembly stay in ram_loader.

Test Plan:
- Frame 00 03 | 12 34 | 00 01 | FF FF | 12 34, back-to-back valid:
  - Three one-cycle writes: addr 0/1/2, data 1234/0001/FFFF.
  - Then 3 reads; done = 1 at edge 5 after the last byte; err_code = 0.
- Same frame with trailer 12 35: RAM written as above, done = 0, err_code = 2.
- LEN = 10 01 with RAM_ADDR_BITS = 12: ERR, err_code = 1, and ram_en is never asserted.
- LEN = 00 00, SUM = 00 00: no writes, no reads, done = 1 at edge 2 after the last byte.
- byte_valid toggling every other cycle during data:
  - Identical RAM contents.
  - byte_ready never drops in data states.
- reset asserted after the 2nd data word of a 3-word frame:
  - All outputs are 0 the next cycle and the state is IDLE.
  - A following start plus a full frame completes with done = 1.
